// File: rtl/slc3_stim_sequencer_if.sv
// Bus between the SLC-3 front-panel stimulus sequencer and whatever drives it:
// table load port, playback control, and the core-facing switch/button outputs.
interface slc3_stim_sequencer_if #(
    parameter int SW_W  = 10,
    parameter int STEPS = 8
);
    localparam int IDX_W = $clog2(STEPS);

    logic             Wr_en;
    logic [IDX_W-1:0] Wr_addr;
    logic [SW_W+1:0]  Wr_data;
    logic             Start;
    logic             Paused;
    logic [SW_W-1:0]  SW_out;
    logic             Run_n;
    logic             Continue_n;
    logic             Busy;
    logic             Done;
    logic             Timeout;
    logic [IDX_W-1:0] Step_idx;

    modport master (
        output Wr_en, Wr_addr, Wr_data, Start, Paused,
        input  SW_out, Run_n, Continue_n, Busy, Done, Timeout, Step_idx
    );

    modport slave (
        input  Wr_en, Wr_addr, Wr_data, Start, Paused,
        output SW_out, Run_n, Continue_n, Busy, Done, Timeout, Step_idx
    );
endinterface

// File: rtl/slc3_stim_sequencer.sv
// SLC-3 front-panel stimulus sequencer: plays a loaded table of steps, each of
// which sets the switch vector and pulses Run or Continue, or waits for Paused.
// All core-facing outputs come straight from registers.
module slc3_stim_sequencer #(
    parameter int SW_W      = 10,
    parameter int STEPS     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    slc3_stim_sequencer_if.slave bus
);
    localparam int IDX_W   = $clog2(STEPS);
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] OP_END  = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_CONT = 2'b10;
    localparam logic [1:0] OP_WAIT = 2'b11;

    localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]     PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(STEPS - 1);
    // The wait counter expires on the cycle its incremented value would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    logic [SW_W+1:0]      table_q [STEPS];

    state_t               state_q,   state_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [SW_W-1:0]      sw_q,      sw_d;
    logic                 run_n_q,   run_n_d;
    logic                 cont_n_q,  cont_n_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q,     tmo_d;
    logic                 btn_run_q, btn_run_d;

    logic [SW_W+1:0]      entry_s;
    logic [1:0]           op_s;
    logic                 advance_s;

    // Table load port; frozen while a sequence is playing so a step can never change under it.
    always_ff @(posedge Clk) begin
        if (bus.Wr_en && !busy_q && (int'(bus.Wr_addr) < STEPS)) begin
            table_q[bus.Wr_addr] <= bus.Wr_data;
        end
    end

    // Next-state and next-output logic for the playback FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sw_d      = sw_q;
        run_n_d   = 1'b1;
        cont_n_d  = 1'b1;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        btn_run_d = btn_run_q;
        advance_s = 1'b0;
        entry_s   = table_q[idx_q];
        op_s      = entry_s[SW_W+1:SW_W];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    idx_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = state_q;
                end
            end
            S_FETCH: begin
                case (op_s)
                    OP_END: begin
                        state_d = S_DONE;
                    end
                    OP_RUN, OP_CONT: begin
                        sw_d      = entry_s[SW_W-1:0];
                        btn_run_d = (op_s == OP_RUN);
                        cnt_d     = '0;
                        state_d   = S_SETUP;
                    end
                    OP_WAIT: begin
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end
                    default: begin
                        state_d = S_DONE;
                    end
                endcase
            end
            S_SETUP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d    = '0;
                    run_n_d  = !btn_run_q;
                    cont_n_d = btn_run_q;
                    state_d  = S_PULSE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE: begin
                // Buttons default to released, so the last pulse cycle lets go here.
                if (cnt_q == PULSE_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    run_n_d  = !btn_run_q;
                    cont_n_d = btn_run_q;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance_s = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.Paused) begin
                    advance_s = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d     = tmo_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step advance: the last table slot finishes the sequence rather than wrapping.
        if (advance_s) begin
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH;
            end
        end else begin
            idx_d = idx_d;
        end

        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset releases both buttons on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            sw_q      <= '0;
            run_n_q   <= 1'b1;
            cont_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            btn_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sw_q      <= sw_d;
            run_n_q   <= run_n_d;
            cont_n_q  <= cont_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            btn_run_q <= btn_run_d;
        end
    end

    assign bus.SW_out     = sw_q;
    assign bus.Run_n      = run_n_q;
    assign bus.Continue_n = cont_n_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Timeout    = timeout_q;
    assign bus.Step_idx   = idx_q;
endmodule
